// File: rtl/fpu_addsub_issue.sv
// FADD.S/FSUB.S issue stage: rm resolve, NaN/Inf handling, registered result and sticky fflags; valid 2 cycles after accept.
// Result held in RESP until rsp_ready_i; define FPU_ADDSUB_OVERLAP_EN to accept a new request on the response handshake.
module fpu_addsub_issue #(
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        sub_i,
    input  logic [2:0]  frm_i,
    input  logic [2:0]  fcsr_frm_i,
    input  logic [4:0]  tag_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_c_o,
    output logic [4:0]  rsp_fflags_o,
    output logic [4:0]  rsp_tag_o,
    output logic [4:0]  fflags_acc_o,
    input  logic        fflags_clr_i
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
`ifdef FPU_ADDSUB_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    logic [1:0]  state_q, state_d;
    logic [31:0] a_q, b_q;
    logic        sub_q;
    logic [2:0]  rm_q;
    logic [4:0]  tag_q;
    logic [31:0] rsp_c_q;
    logic [4:0]  rsp_f_q, rsp_tag_q, acc_q, acc_d;
    logic        req_acc, rsp_hs;

    assign rsp_valid_o  = (state_q == ST_RESP);
    assign req_ready_o  = (state_q == ST_IDLE) || (OVERLAP && rsp_valid_o && rsp_ready_i);
    assign req_acc      = req_valid_i && req_ready_o;
    assign rsp_hs       = rsp_valid_o && rsp_ready_i;
    assign rsp_c_o      = rsp_c_q;
    assign rsp_fflags_o = rsp_f_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign fflags_acc_o = acc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_acc) state_d = ST_CALC;
            ST_CALC: state_d = ST_RESP;
            ST_RESP: if (rsp_hs) state_d = req_acc ? ST_CALC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A clear coinciding with a handshake keeps the newly delivered flags.
    assign acc_d = (fflags_clr_i ? 5'd0 : acc_q) | (rsp_hs ? rsp_f_q : 5'd0);

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    // Finite-operand add core; x always carries the larger magnitude.
    logic [31:0] b_eff, x, y, core_c;
    logic [4:0]  core_f, lz, lsh;
    logic        a_big, eff_sub, res_sign, g, st, nx, uf, rnd_up, ovf_inf;
    logic [9:0]  ex, ey, dexp, em1, en, e_out;
    logic [26:0] mx_ext, my_ext, my_al, norm;
    logic [27:0] sum;
    logic [24:0] r;
    logic [22:0] mant;

    assign b_eff = {b_q[31] ^ sub_q, b_q[30:0]};

    always_comb begin
        a_big   = a_q[30:0] >= b_eff[30:0];
        x       = a_big ? a_q : b_eff;
        y       = a_big ? b_eff : a_q;
        eff_sub = x[31] ^ y[31];
        ex      = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
        ey      = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
        mx_ext  = {|x[30:23], x[22:0], 3'b000};
        my_ext  = {|y[30:23], y[22:0], 3'b000};
        dexp    = ex - ey;
        if (dexp >= 10'd27) begin
            my_al = {26'd0, |my_ext};
        end else begin
            my_al = (my_ext >> dexp) | {26'd0, |(my_ext & ((27'd1 << dexp) - 27'd1))};
        end
        sum = eff_sub ? ({1'b0, mx_ext} - {1'b0, my_al}) : ({1'b0, mx_ext} + {1'b0, my_al});
        lz  = lzc27(sum[26:0]);
        em1 = ex - 10'd1;
        if (sum[27]) begin
            norm = {sum[27:2], |sum[1:0]};
            en   = ex + 10'd1;
            lsh  = 5'd0;
        end else begin
            // Normalisation stops at the minimum exponent so subnormals stay subnormal.
            lsh  = ({5'd0, lz} > em1) ? em1[4:0] : lz;
            norm = sum[26:0] << lsh;
            en   = ex - {5'd0, lsh};
        end
        res_sign = (sum == 28'd0 && eff_sub) ? (rm_q == 3'b010) : x[31];
        g  = norm[2];
        st = |norm[1:0];
        nx = g || st;
        case (rm_q)
            3'b000:  rnd_up = g && (st || norm[3]);
            3'b010:  rnd_up = nx && res_sign;
            3'b011:  rnd_up = nx && !res_sign;
            3'b100:  rnd_up = g;
            default: rnd_up = 1'b0;
        endcase
        r     = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        e_out = r[24] ? en + 10'd1 : (r[23] ? en : 10'd0);
        mant  = r[24] ? r[23:1] : r[22:0];
        uf    = nx && (e_out == 10'd0);
        case (rm_q)
            3'b001:  ovf_inf = 1'b0;
            3'b010:  ovf_inf = res_sign;
            3'b011:  ovf_inf = !res_sign;
            default: ovf_inf = 1'b1;
        endcase
        if (e_out >= 10'd255) begin
            core_c = ovf_inf ? {res_sign, 8'hFF, 23'd0} : {res_sign, 8'hFE, 23'h7FFFFF};
            core_f = 5'b00101;
        end else begin
            core_c = {res_sign, e_out[7:0], mant};
            core_f = {3'b000, uf, nx};
        end
    end

    logic        a_nan, b_nan, a_inf, b_inf;
    logic [31:0] res_c;
    logic [4:0]  res_f;

    assign a_nan = (&a_q[30:23]) && (|a_q[22:0]);
    assign b_nan = (&b_q[30:23]) && (|b_q[22:0]);
    assign a_inf = (&a_q[30:23]) && !(|a_q[22:0]);
    assign b_inf = (&b_q[30:23]) && !(|b_q[22:0]);

    always_comb begin
        res_c = core_c;
        res_f = core_f;
        if (rm_q inside {3'b101, 3'b110, 3'b111}) begin
            res_c = CANON_NAN;
            res_f = 5'b10000;
        end else if (a_nan || b_nan) begin
            res_c = CANON_NAN;
            res_f = {(a_nan && !a_q[22]) || (b_nan && !b_q[22]), 4'b0000};
        end else if (a_inf && b_inf && (a_q[31] != b_eff[31])) begin
            res_c = CANON_NAN;
            res_f = 5'b10000;
        end else if (a_inf) begin
            res_c = a_q;
            res_f = 5'b00000;
        end else if (b_inf) begin
            res_c = b_eff;
            res_f = 5'b00000;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            rm_q      <= '0;
            tag_q     <= '0;
            rsp_c_q   <= '0;
            rsp_f_q   <= '0;
            rsp_tag_q <= '0;
            acc_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (req_acc) begin
                a_q   <= rs1_i;
                b_q   <= rs2_i;
                sub_q <= sub_i;
                tag_q <= tag_i;
                rm_q  <= (frm_i == 3'b111) ? fcsr_frm_i : frm_i;
            end
            if (state_q == ST_CALC) begin
                rsp_c_q   <= res_c;
                rsp_f_q   <= res_f;
                rsp_tag_q <= tag_q;
            end
        end
    end
endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Scoreboarded bench for fpu_addsub_issue: directed vectors, monitor checks every presented response.
module tb_fpu_addsub_issue;
    logic        clk_i, rstn_i, req_valid_i, req_ready_o, sub_i, rsp_valid_o, rsp_ready_i, fflags_clr_i;
    logic [31:0] rs1_i, rs2_i, rsp_c_o;
    logic [2:0]  frm_i, fcsr_frm_i;
    logic [4:0]  tag_i, rsp_fflags_o, rsp_tag_o, fflags_acc_o;

    fpu_addsub_issue dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .sub_i(sub_i),
        .frm_i(frm_i), .fcsr_frm_i(fcsr_frm_i), .tag_i(tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_c_o(rsp_c_o), .rsp_fflags_o(rsp_fflags_o), .rsp_tag_o(rsp_tag_o),
        .fflags_acc_o(fflags_acc_o), .fflags_clr_i(fflags_clr_i)
    );

`ifdef FPU_ADDSUB_OVERLAP_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 3;
`endif

    typedef struct {
        logic [31:0] c;
        logic [4:0]  f;
        logic [4:0]  tag;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   rise_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   prev_vld = 1'b0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares the head entry whenever a response is presented, pops on handshake.
    always @(negedge clk_i) begin
        if (rstn_i && rsp_valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", {31'd0, rsp_valid_o}, 32'd0);
            end else begin
                if (!prev_vld) begin
                    rise_cyc.push_back(cyc);
                    check("latency", cyc - sb[0].acc_cyc, 32'd2);
                end
                check("rsp_c", rsp_c_o, sb[0].c);
                check("rsp_fflags", {27'd0, rsp_fflags_o}, {27'd0, sb[0].f});
                check("rsp_tag", {27'd0, rsp_tag_o}, {27'd0, sb[0].tag});
                if (rsp_ready_i) void'(sb.pop_front());
            end
        end
        prev_vld = rsp_valid_o;
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [2:0] frm,
                        input logic [2:0] fcsr, input logic [4:0] tg, input logic [31:0] ec,
                        input logic [4:0] ef, input bit expect_rsp);
        int n = 0;
        bit ok = 1'b0;
        req_valid_i = 1'b1;
        rs1_i = a; rs2_i = b; sub_i = s; frm_i = frm; fcsr_frm_i = fcsr; tag_i = tg;
        while (!ok && n < 50) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                ok = 1'b1;
                if (expect_rsp) sb.push_back('{c: ec, f: ef, tag: tg, acc_cyc: cyc});
            end
            @(posedge clk_i); #1;
            n++;
        end
        req_valid_i = 1'b0;
        check("req_accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0; req_valid_i = 1'b0; rs1_i = '0; rs2_i = '0; sub_i = 1'b0;
        frm_i = '0; fcsr_frm_i = '0; tag_i = '0; rsp_ready_i = 1'b1; fflags_clr_i = 1'b0;
        #12;
        check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst_rsp_c", rsp_c_o, 32'd0);
        check("rst_rsp_fflags", {27'd0, rsp_fflags_o}, 32'd0);
        check("rst_rsp_tag", {27'd0, rsp_tag_o}, 32'd0);
        check("rst_acc", {27'd0, fflags_acc_o}, 32'd0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        @(posedge clk_i); #1;

        send(32'h3F800000, 32'h40000000, 1'b0, 3'b000, 3'b000, 5'd7, 32'h40400000, 5'b00000, 1'b1);
        drain();
        check("acc_after_add", {27'd0, fflags_acc_o}, 32'h00);
        send(32'h7F800000, 32'h7F800000, 1'b1, 3'b000, 3'b000, 5'd1, 32'h7FC00000, 5'b10000, 1'b1);
        drain();
        check("acc_after_inf_sub", {27'd0, fflags_acc_o}, 32'h10);
        send(32'h7F800001, 32'h3F800000, 1'b0, 3'b000, 3'b000, 5'd2, 32'h7FC00000, 5'b10000, 1'b1);
        send(32'h7FC00001, 32'h3F800000, 1'b0, 3'b000, 3'b000, 5'd3, 32'h7FC00000, 5'b00000, 1'b1);
        drain();
        check("acc_after_qnan", {27'd0, fflags_acc_o}, 32'h10);
        send(32'h3F800000, 32'h3F800000, 1'b0, 3'b111, 3'b101, 5'd4, 32'h7FC00000, 5'b10000, 1'b1);
        send(32'h3F800000, 32'h33800000, 1'b0, 3'b111, 3'b001, 5'd5, 32'h3F800000, 5'b00001, 1'b1);
        drain();
        check("acc_after_dyn_rtz", {27'd0, fflags_acc_o}, 32'h11);

        send(32'h3F800000, 32'h3F800000, 1'b1, 3'b000, 3'b000, 5'd8,  32'h00000000, 5'b00000, 1'b1);
        send(32'h3F800000, 32'h3F800000, 1'b1, 3'b010, 3'b000, 5'd9,  32'h80000000, 5'b00000, 1'b1);
        send(32'hFF800000, 32'h3F800000, 1'b0, 3'b000, 3'b000, 5'd10, 32'hFF800000, 5'b00000, 1'b1);
        send(32'h3F800000, 32'h7F800000, 1'b1, 3'b000, 3'b000, 5'd11, 32'hFF800000, 5'b00000, 1'b1);
        send(32'h3F800000, 32'hBF000000, 1'b0, 3'b000, 3'b000, 5'd12, 32'h3F000000, 5'b00000, 1'b1);
        send(32'h3F800000, 32'h3F800000, 1'b0, 3'b110, 3'b000, 5'd13, 32'h7FC00000, 5'b10000, 1'b1);
        send(32'h3F800000, 32'h33800000, 1'b0, 3'b000, 3'b000, 5'd14, 32'h3F800000, 5'b00001, 1'b1);
        send(32'h3F800000, 32'h33800000, 1'b0, 3'b011, 3'b000, 5'd15, 32'h3F800001, 5'b00001, 1'b1);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b001, 3'b000, 5'd16, 32'h7F7FFFFF, 5'b00101, 1'b1);
        send(32'h00000001, 32'h00000001, 1'b0, 3'b000, 3'b000, 5'd17, 32'h00000002, 5'b00000, 1'b1);
        send(32'hFF800000, 32'hFF800000, 1'b0, 3'b000, 3'b000, 5'd18, 32'hFF800000, 5'b00000, 1'b1);
        send(32'h7F800000, 32'h7FC00000, 1'b0, 3'b000, 3'b000, 5'd19, 32'h7FC00000, 5'b00000, 1'b1);
        drain();

        fflags_clr_i = 1'b1;
        @(posedge clk_i); #1;
        fflags_clr_i = 1'b0;
        check("acc_cleared", {27'd0, fflags_acc_o}, 32'h00);

        rsp_ready_i = 1'b0;
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b000, 3'b000, 5'd20, 32'h7F800000, 5'b00101, 1'b1);
        @(posedge clk_i); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_req_ready", {31'd0, req_ready_o}, 32'd0);
            check("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
            @(posedge clk_i); #1;
        end
        rsp_ready_i = 1'b1;
        fflags_clr_i = 1'b1;
        @(posedge clk_i); #1;
        fflags_clr_i = 1'b0;
        check("acc_clr_with_hs", {27'd0, fflags_acc_o}, 32'h05);
        check("bp_drained", sb.size(), 32'd0);

        rise_cyc.delete();
        send(32'h3F800000, 32'h40000000, 1'b0, 3'b000, 3'b000, 5'd21, 32'h40400000, 5'b00000, 1'b1);
        send(32'h40000000, 32'h40000000, 1'b0, 3'b000, 3'b000, 5'd22, 32'h40800000, 5'b00000, 1'b1);
        drain();
        check("b2b_count", rise_cyc.size(), 32'd2);
        if (rise_cyc.size() >= 2) check("b2b_gap", rise_cyc[1] - rise_cyc[0], GAP);

        send(32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 3'b000, 5'd23, 32'h0, 5'b0, 1'b0);
        #2 rstn_i = 1'b0;
        #1;
        check("midrst_req_ready", {31'd0, req_ready_o}, 32'd1);
        check("midrst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("midrst_rsp_c", rsp_c_o, 32'd0);
        check("midrst_rsp_fflags", {27'd0, rsp_fflags_o}, 32'd0);
        check("midrst_rsp_tag", {27'd0, rsp_tag_o}, 32'd0);
        check("midrst_acc", {27'd0, fflags_acc_o}, 32'd0);
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        #3 rstn_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check("no_rsp_after_rst", {31'd0, rsp_valid_o}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
